// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package video_timing_pkg;

    // Default 320x480 mode (H_TOTAL = 400, V_TOTAL = 525)
    localparam int DEF_CNT_W     = 10;
    localparam int DEF_H_VISIBLE = 320;
    localparam int DEF_H_FP      = 8;
    localparam int DEF_H_SYNC    = 48;
    localparam int DEF_H_BP      = 24;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    // Sync polarity: the level driven while the sync window is active
    localparam bit ACTIVE_LOW  = 1'b0;
    localparam bit ACTIVE_HIGH = 1'b1;

    // Total period of one axis in counter steps
    function automatic int calc_total(input int visible, input int fp,
                                      input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// One raster axis: wrapping counter with visible/sync window decode.
// Latency: cnt and sync update one clk after an inc cycle; cnt_next/active_next are same-cycle.
// Backpressure: none; the counter simply holds while inc is low.
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int VISIBLE  = DEF_H_VISIBLE,
    parameter int FP       = DEF_H_FP,
    parameter int SYNC     = DEF_H_SYNC,
    parameter int BP       = DEF_H_BP,
    parameter bit SYNC_POL = ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next,
    output logic             wrap,
    output logic             active_next,
    output logic             sync
);

    localparam int TOTAL = calc_total(VISIBLE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] VIS_L    = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SS_L     = CNT_W'(VISIBLE + FP);
    localparam logic [CNT_W-1:0] SE_L     = CNT_W'(VISIBLE + FP + SYNC);

    logic sync_act_next;

    // Next count and window decode, so registered outputs line up with the count
    always_comb begin
        wrap          = inc && (cnt == LAST);
        cnt_next      = cnt;
        if (inc) begin
            cnt_next = wrap ? '0 : cnt + 1'b1;
        end
        active_next   = (cnt_next < VIS_L);
        sync_act_next = (cnt_next >= SS_L) && (cnt_next < SE_L);
    end

    // Counter and sync level; reset parks on the last position so the first tick enters 0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= LAST;
            sync <= !SYNC_POL;
        end else begin
            cnt  <= cnt_next;
            sync <= sync_act_next ? SYNC_POL : !SYNC_POL;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, syncs, windows and event strobes.
// Latency: all outputs registered, coincident with the hcounter/vcounter they describe.
// Backpressure: pix_en=0 holds counters/levels and forces strobes low.
// Optional: VIDEO_TIMING_LINE_MATCH_EN builds the line-compare strobe; otherwise line_match=0.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = ACTIVE_LOW,
    parameter bit VSYNC_POL = ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [CNT_W-1:0] match_line,
    output logic [CNT_W-1:0] hcounter,
    output logic [CNT_W-1:0] vcounter,
    output logic             hsync,
    output logic             vsync,
    output logic             visible,
    output logic             writable,
    output logic             frame_start,
    output logic             vblank_start,
    output logic             line_match
);

    localparam int H_TOTAL = calc_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam logic [CNT_W-1:0] V_VIS_L = CNT_W'(V_VISIBLE);

    if (CNT_W <= 0 || CNT_W > 30) begin : g_bad_cnt_w
        $error("video_timing_gen: CNT_W out of range");
    end
    if (H_VISIBLE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_VISIBLE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("video_timing_gen: timing parameters must be non-zero");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end

    logic             h_wrap, v_wrap;
    logic             h_act_next, v_act_next;
    logic [CNT_W-1:0] h_next_unused, v_next;

    timing_axis #(
        .CNT_W(CNT_W), .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .SYNC_POL(HSYNC_POL)
    ) u_h_axis (
        .clk(clk), .rst(rst), .inc(pix_en),
        .cnt(hcounter), .cnt_next(h_next_unused), .wrap(h_wrap),
        .active_next(h_act_next), .sync(hsync)
    );

    timing_axis #(
        .CNT_W(CNT_W), .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .SYNC_POL(VSYNC_POL)
    ) u_v_axis (
        .clk(clk), .rst(rst), .inc(pix_en & h_wrap),
        .cnt(vcounter), .cnt_next(v_next), .wrap(v_wrap),
        .active_next(v_act_next), .sync(vsync)
    );

    // Windows and strobes; v_wrap implies a tick entering (0,0), h_wrap a tick entering column 0
    always_ff @(posedge clk) begin
        if (rst) begin
            visible      <= 1'b0;
            writable     <= 1'b1;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            visible      <= h_act_next && v_act_next;
            writable     <= (v_next >= V_VIS_L);
            frame_start  <= v_wrap;
            vblank_start <= h_wrap && (v_next == V_VIS_L);
        end
    end

`ifdef VIDEO_TIMING_LINE_MATCH_EN
    // match_line is sampled only at the line boundary, so mid-line changes apply from the next line
    always_ff @(posedge clk) begin
        if (rst) begin
            line_match <= 1'b0;
        end else begin
            line_match <= h_wrap && (match_line == v_next);
        end
    end
`else
    logic match_line_unused;
    assign match_line_unused = ^match_line;
    assign line_match        = 1'b0;
`endif

`ifdef SIM
    // Frame boundary trace
    always_ff @(posedge clk) begin
        if (frame_start) begin
            $display("video_timing_gen: frame_start at %0t", $time);
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a small raster so whole frames fit in the run.
// Reference model tracks the absolute pixel position within the frame and derives every output from it.
// Also exercises reset, pix_en gating, sync windows, vblank and line-compare corner cases.
module tb_video_timing_gen;

    localparam int CW = 6;
    localparam int HV = 12, HF = 2, HS = 4, HB = 3;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 21
    localparam int VT = VV + VF + VS + VB;   // 15
    localparam int FT = HT * VT;             // 315
    localparam bit HP = 1'b1;
    localparam bit VP = 1'b0;
`ifdef VIDEO_TIMING_LINE_MATCH_EN
    localparam bit LM_EN = 1'b1;
`else
    localparam bit LM_EN = 1'b0;
`endif

    logic          clk, rst, pix_en;
    logic [CW-1:0] match_line;
    logic [CW-1:0] hcounter, vcounter;
    logic          hsync, vsync, visible, writable;
    logic          frame_start, vblank_start, line_match;

    video_timing_gen #(
        .CNT_W(CW), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .match_line(match_line),
        .hcounter(hcounter), .vcounter(vcounter), .hsync(hsync), .vsync(vsync),
        .visible(visible), .writable(writable), .frame_start(frame_start),
        .vblank_start(vblank_start), .line_match(line_match)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Model: position within the frame, plus strobe expectations for the last cycle
    int n = FT - 1;
    bit e_fs, e_vb, e_lm;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Apply one clk of inputs, then advance the model from the same inputs
    task automatic step(input logic r, input logic pe, input logic [CW-1:0] ml);
        int h, v;
        rst = r; pix_en = pe; match_line = ml;
        @(posedge clk);
        #1;
        e_fs = 0; e_vb = 0; e_lm = 0;
        if (r) begin
            n = FT - 1;
        end else if (pe) begin
            n = (n + 1) % FT;
            h = n % HT;
            v = n / HT;
            e_fs = (h == 0) && (v == 0);
            e_vb = (h == 0) && (v == VV);
            e_lm = LM_EN && (h == 0) && (v == int'(ml));
        end
    endtask

    function automatic logic [31:0] model_vec();
        int h, v;
        bit hs, vs, vis, wr;
        h   = n % HT;
        v   = n / HT;
        hs  = (h >= HV + HF && h < HV + HF + HS) ? HP : !HP;
        vs  = (v >= VV + VF && v < VV + VF + VS) ? VP : !VP;
        vis = (h < HV) && (v < VV);
        wr  = (v >= VV);
        return {13'd0, CW'(h), CW'(v), hs, vs, vis, wr, e_fs, e_vb, e_lm};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {13'd0, hcounter, vcounter, hsync, vsync, visible, writable,
                frame_start, vblank_start, line_match};
    endfunction

    typedef struct {
        logic r;
        logic pe;
        int   eh;
        int   ev;
        logic efs;
        logic evis;
        logic ewr;
    } vec_t;

    vec_t tbl[7];
    logic [CW-1:0] ml;

    initial begin
        int period, stretch, hold_bad, first_h, width, vb_cnt, lm_cnt, vb_ok, lm_line, k;
        logic [CW-1:0] prev_h, prev_v;
        logic prev_fs;

        rst = 1'b1; pix_en = 1'b0; match_line = '0; ml = '0;

        // Reset, release, hold, advance, and reset again with pix_en low
        tbl[0] = '{1'b1, 1'b1, HT - 1, VT - 1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 0,      0,      1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 0,      0,      1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1,      0,      1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 2,      0,      1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, HT - 1, VT - 1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 0,      0,      1'b1, 1'b1, 1'b0};

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].r, tbl[i].pe, ml);
            check($sformatf("table_row%0d", i),
                  {17'd0, hcounter, vcounter, frame_start, visible, writable},
                  {17'd0, CW'(tbl[i].eh), CW'(tbl[i].ev), tbl[i].efs, tbl[i].evis, tbl[i].ewr});
        end

        // Random run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 4))
                    0: ml = '0;
                    1: ml = CW'(3);
                    2: ml = CW'(VT - 1);
                    3: ml = CW'(VT);
                    default: ml = CW'(63);
                endcase
            end
            step($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0, ml);
            check("random", dut_vec(), model_vec());
        end

        // Reset mid-frame with pix_en low, then release
        step(1'b1, 1'b0, ml);
        check("reset_values", dut_vec(),
              {13'd0, CW'(HT - 1), CW'(VT - 1), !HP, !VP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        step(1'b0, 1'b1, ml);
        check("release_first_tick", {24'd0, hcounter, vcounter, frame_start},
              {24'd0, CW'(0), CW'(0), 1'b1});

        // Alternating pix_en: frame period doubles, strobes stay one clk, counters hold
        period = -1; stretch = 0; hold_bad = 0; prev_fs = 1'b1;
        for (k = 1; k <= 2000 && period < 0; k++) begin
            prev_h = hcounter; prev_v = vcounter;
            step(1'b0, k[0] == 1'b0, ml);
            if (k[0] == 1'b1 && (hcounter != prev_h || vcounter != prev_v)) hold_bad++;
            if (prev_fs && frame_start) stretch++;
            prev_fs = frame_start;
            if (frame_start) period = k;
        end
        check("toggle_frame_period", period, 2 * FT);
        check("strobe_stretch", stretch, 0);
        check("hold_on_idle", hold_bad, 0);

        // hsync window width and start column
        for (k = 0; k < 100 && hcounter != 0; k++) step(1'b0, 1'b1, ml);
        first_h = -1; width = 0;
        for (int j = 0; j < HT; j++) begin
            if (hsync == HP) begin
                width++;
                if (first_h < 0) first_h = hcounter;
            end
            step(1'b0, 1'b1, ml);
        end
        check("hsync_width", width, HS);
        check("hsync_start", first_h, HV + HF);

        // One full frame: single vblank_start at (0,VV) where writable rises; line_match at line 3
        ml = CW'(3); vb_cnt = 0; lm_cnt = 0; vb_ok = 0;
        for (int j = 0; j < FT; j++) begin
            step(1'b0, 1'b1, ml);
            if (vblank_start) begin
                vb_cnt++;
                if (hcounter == 0 && vcounter == CW'(VV) && writable) vb_ok++;
            end
            if (line_match) lm_cnt++;
        end
        check("vblank_count", vb_cnt, 1);
        check("vblank_position", vb_ok, 1);
        check("line_match_count", lm_cnt, LM_EN ? 1 : 0);

        // Mid-line change: target moved from 5 to 7 during line 4 fires at line 7 only
        ml = CW'(5);
        for (k = 0; k < 2 * FT && !(vcounter == 4 && hcounter == 5); k++) step(1'b0, 1'b1, ml);
        ml = CW'(7); lm_cnt = 0; lm_line = -1;
        for (k = 0; k < 2 * FT && vcounter != 9; k++) begin
            step(1'b0, 1'b1, ml);
            if (line_match) begin
                lm_cnt++;
                lm_line = vcounter;
            end
        end
        check("midline_change_count", lm_cnt, LM_EN ? 1 : 0);
        check("midline_change_line", lm_line, LM_EN ? 7 : -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 400x525 VGA-derived timer.
- Sits at the head of the GPU pipeline. Drives the hsync/vsync pins, pixel/line counters, visible and writable windows, and single-cycle event strobes used by the PPU and the CPU-facing interrupt logic.
- Adds three things over the fixed timer: per-axis porch/sync parameters, sync polarity, and a pixel-enable so it can run from a faster system clock.

Parameters:
- CNT_W, 10, width of hcounter/vcounter.
- H_VISIBLE, 320, visible pixels per line.
- H_FP, 8, horizontal front porch.
- H_SYNC, 48, horizontal sync width.
- H_BP, 24, horizontal back porch (H_TOTAL = 400).
- V_VISIBLE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch (V_TOTAL = 525).
- HSYNC_POL, 0, active level of hsync (0 = active-low).
- VSYNC_POL, 0, active level of vsync.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- pix_en  in  1  pixel tick; counters advance only on cycles where pix_en=1.
- match_line  in  CNT_W  line-compare target.
- hcounter  out  CNT_W  current pixel column.
- vcounter  out  CNT_W  current line.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- visible  out  1  hcounter<H_VISIBLE and vcounter<V_VISIBLE.
- writable  out  1  vcounter>=V_VISIBLE (VRAM safe to write).
- frame_start  out  1  strobe on entry to (0,0).
- vblank_start  out  1  strobe on entry to (0,V_VISIBLE).
- line_match  out  1  strobe on entry to (0,match_line).

Behaviour:
- All outputs are registered and computed from the next counter values, so every output is coincident with the hcounter/vcounter it describes. No combinational path exists from any input to any output.
- Reset values: hcounter=H_TOTAL-1, vcounter=V_TOTAL-1, hsync=!HSYNC_POL, vsync=!VSYNC_POL, visible=0, writable=1, all strobes 0.
  - The first pix_en cycle after reset enters (0,0) and fires frame_start.
  - Reset asserted mid-frame returns to these values on the next clk edge, regardless of pix_en.
- Counting on each pix_en=1 cycle:
  - hcounter wraps from H_TOTAL-1 to 0, otherwise increments.
  - vcounter changes only when hcounter wraps: it wraps from V_TOTAL-1 to 0, otherwise increments.
- pix_en=0: counters and level outputs (hsync, vsync, visible, writable) hold.
- Strobes: each is high for exactly one clk, only on the cycle after the advancing tick that enters its position. They are 0 whenever pix_en was 0, so a strobe never stretches.
- hsync active for H_VISIBLE+H_FP <= hcounter < H_VISIBLE+H_FP+H_SYNC (328..375 by default).
- vsync active for V_VISIBLE+V_FP <= vcounter < V_VISIBLE+V_FP+V_SYNC (490..491 by default), full lines.
- match_line:
  - Sampled into an internal register on every hcounter wrap.
  - Compared against vcounter_next at that wrap.
  - Changing match_line mid-line takes effect from the next line boundary.
  - match_line >= V_TOTAL never fires.
  - match_line = 0 fires in the same cycle as frame_start.
- Arithmetic: totals computed as localparams. Elaboration error if H_TOTAL or V_TOTAL exceeds 2^CNT_W, or if any parameter is 0.
- Under `SIM`, $display the time on every frame_start.

Optional Feature:
- VIDEO_TIMING_LINE_MATCH_EN
- Defined: match_line register, comparator and line_match strobe are implemented as above.
- Undefined: match_line is ignored, no register is built, and line_match is tied to 0.

Decomposition:
- Package video_timing_pkg:
  - Default timing constants for the 320x480 mode.
  - Polarity constants ACTIVE_LOW/ACTIVE_HIGH.
  - A function computing totals from porch/sync values.
- One sub-module, timing_axis: a generic wrapping counter with inc/wrap-out and window decode (visible, sync).
  - Instantiated twice: horizontal with inc=pix_en; vertical with inc=pix_en&h_wrap.

Test Plan:
- Reset hold, then release with pix_en=1 -> cycle 1 shows (0,0), frame_start=1, visible=1, writable=0. Next frame_start occurs exactly 210000 cycles later.
- Steady run, defaults:
  - hsync low exactly 48 cycles per line, starting when hcounter=328.
  - vsync low exactly during vcounter 490..491.
  - vblank_start at (0,480), where writable rises.
- pix_en toggling 1,0 -> frame period 420000 clk; every strobe width stays exactly 1 clk; counters hold on pix_en=0 cycles.
- With VIDEO_TIMING_LINE_MATCH_EN:
  - match_line=100 -> one line_match per frame at (0,100).
  - match_line changed to 200 mid-line 150 -> next pulse at line 200 in the same frame.
  - match_line=600 -> no pulse.
- rst asserted at (200,300) with pix_en=0 -> next clk shows reset values. Release -> first tick gives (0,0) and frame_start.
- HSYNC_POL=1, VSYNC_POL=1, H_VISIBLE=256 -> sync levels inverted (idle low). visible width 256 cycles. Timing windows shift accordingly.
